pipe_reg_file: RTL and testbench



---
 rtl/pipe_reg_file.sv | 136 +++++++++++++
 tb/tb_pipe_reg_file.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_file.sv
// ----------------------------------------------------------------------------
// pipe_reg_file
//
// Decode-stage register file for the pipelined datapath. Holds NREGS x DATA_W
// architectural registers plus a busy scoreboard. Decode reads operands and
// issues destinations; writeback retires them.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous, active-high; reloads contents, clears busy
//   rd_addr1   in   read port 1 address
//   rd_addr2   in   read port 2 address
//   rd_data1   out  read port 1 data (combinational, write-first bypass)
//   rd_data2   out  read port 2 data (combinational, write-first bypass)
//   wr_en      in   writeback strobe
//   wr_addr    in   writeback address
//   wr_data    in   writeback data
//   iss_en     in   issue strobe, marks iss_addr as having a pending write
//   iss_addr   in   destination register being issued
//   busy1      out  rd_addr1 has an unretired pending write
//   busy2      out  rd_addr2 has an unretired pending write
//   hazard     out  busy1 | busy2, decode stall request
// ----------------------------------------------------------------------------
module pipe_reg_file #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int RESET_MODE = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard
);

  localparam int NREGS = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] mem_r [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic [NREGS-1:0]  busy_nxt_s;
  logic              wr_kept_s;
  logic              iss_kept_s;
  logic              rd1_zero_s;
  logic              rd2_zero_s;
  logic              byp1_s;
  logic              byp2_s;

  // Reset contents of register idx: either zero or its own index, truncated.
  function automatic logic [DATA_W-1:0] reset_val(input int idx);
    if (RESET_MODE == 1) begin
      return DATA_W'(idx);
    end else begin
      return {DATA_W{1'b0}};
    end
  endfunction

  // Hardwired-zero filtering of writes, issues and reads at address 0.
  always_comb begin
    wr_kept_s  = wr_en  & ~(ZERO_EN & (wr_addr  == ADDR_ZERO));
    iss_kept_s = iss_en & ~(ZERO_EN & (iss_addr == ADDR_ZERO));
    rd1_zero_s = ZERO_EN & (rd_addr1 == ADDR_ZERO);
    rd2_zero_s = ZERO_EN & (rd_addr2 == ADDR_ZERO);
    byp1_s     = wr_en & (wr_addr == rd_addr1);
    byp2_s     = wr_en & (wr_addr == rd_addr2);
  end

  // Next busy vector: retire clears first, then issue sets, so a new producer
  // on the same register supersedes the one retiring on that edge.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_en) begin
      busy_nxt_s[wr_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (iss_kept_s) begin
      busy_nxt_s[iss_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Register array and scoreboard state; reset overrides any write or issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= reset_val(i);
      end
      busy_r <= {NREGS{1'b0}};
    end else begin
      if (wr_kept_s) begin
        mem_r[wr_addr] <= wr_data;
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports: hardwired zero beats the bypass, which beats the array.
  always_comb begin
    if (rd1_zero_s) begin
      rd_data1 = {DATA_W{1'b0}};
    end else if (byp1_s) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = mem_r[rd_addr1];
    end
    if (rd2_zero_s) begin
      rd_data2 = {DATA_W{1'b0}};
    end else if (byp2_s) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = mem_r[rd_addr2];
    end
  end

  // Hazard flags: a register retiring this cycle is served by the bypass,
  // so it does not stall decode.
  always_comb begin
    busy1  = busy_r[rd_addr1] & ~byp1_s & ~rd1_zero_s;
    busy2  = busy_r[rd_addr2] & ~byp2_s & ~rd2_zero_s;
    hazard = busy1 | busy2;
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
module tb_pipe_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       iss_en = 1'b0;
  logic [2:0] rd_addr1 = 3'd0;
  logic [2:0] rd_addr2 = 3'd0;
  logic [2:0] wr_addr = 3'd0;
  logic [2:0] iss_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;

  logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic       busy1_a, busy2_a, hazard_a, busy1_b, busy2_b, hazard_b;

  // Instance A: defaults (index reset contents, no zero register).
  pipe_reg_file #(.DATA_W(8), .ADDR_W(3), .RESET_MODE(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_a), .rd_data2(rd2_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy1(busy1_a), .busy2(busy2_a), .hazard(hazard_a));

  // Instance B: zero reset contents, register 0 hardwired.
  pipe_reg_file #(.DATA_W(8), .ADDR_W(3), .RESET_MODE(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_b), .rd_data2(rd2_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy1(busy1_b), .busy2(busy2_b), .hazard(hazard_b));

  typedef struct {
    int         dut;
    logic [7:0] e_rd1;
    logic [7:0] e_rd2;
    logic       e_b1;
    logic       e_b2;
    logic       e_hz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: per-instance contents and pending-write flags.
  logic [7:0] m_mem [2][8];
  bit         m_busy [2][8];
  bit         model_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic bit is_zero_reg(input int d, input logic [2:0] a);
    return (d == 1) && (a == 3'd0);
  endfunction

  function automatic logic [7:0] exp_rd(input int d, input logic [2:0] a,
                                        input logic we, input logic [2:0] wa,
                                        input logic [7:0] wd);
    if (is_zero_reg(d, a)) return 8'd0;
    if (we && wa == a) return wd;
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(input int d, input logic [2:0] a,
                                    input logic we, input logic [2:0] wa);
    if (is_zero_reg(d, a)) return 1'b0;
    if (we && wa == a) return 1'b0;
    return m_busy[d][a];
  endfunction

  task automatic check(input string name, input int d, input logic [7:0] act,
                       input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, expv);
    end
  endtask

  // One decode cycle: drive inputs, queue expectations, advance the model.
  task automatic cyc(input logic rst, input logic we, input logic [2:0] wa,
                     input logic [7:0] wd, input logic ie, input logic [2:0] ia,
                     input logic [2:0] a1, input logic [2:0] a2);
    exp_t e;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr1 = a1; rd_addr2 = a2;
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        e.dut   = d;
        e.e_rd1 = exp_rd(d, a1, we, wa, wd);
        e.e_rd2 = exp_rd(d, a2, we, wa, wd);
        e.e_b1  = exp_busy(d, a1, we, wa);
        e.e_b2  = exp_busy(d, a2, we, wa);
        e.e_hz  = e.e_b1 | e.e_b2;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[d][i]  = (d == 0) ? 8'(i) : 8'd0;
          m_busy[d][i] = 1'b0;
        end
      end else begin
        if (we && !is_zero_reg(d, wa)) m_mem[d][wa] = wd;
        if (we) m_busy[d][wa] = 1'b0;
        if (ie && !is_zero_reg(d, ia)) m_busy[d][ia] = 1'b1;
      end
    end
    if (rst) model_ok = 1'b1;
    #1;
  endtask

  // Monitor: outputs are combinational, so each queued expectation is
  // compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.dut == 0) begin
        check("rd_data1", 0, rd1_a, mon_e.e_rd1);
        check("rd_data2", 0, rd2_a, mon_e.e_rd2);
        check("busy1", 0, {7'd0, busy1_a}, {7'd0, mon_e.e_b1});
        check("busy2", 0, {7'd0, busy2_a}, {7'd0, mon_e.e_b2});
        check("hazard", 0, {7'd0, hazard_a}, {7'd0, mon_e.e_hz});
      end else begin
        check("rd_data1", 1, rd1_b, mon_e.e_rd1);
        check("rd_data2", 1, rd2_b, mon_e.e_rd2);
        check("busy1", 1, {7'd0, busy1_b}, {7'd0, mon_e.e_b1});
        check("busy2", 1, {7'd0, busy2_b}, {7'd0, mon_e.e_b2});
        check("hazard", 1, {7'd0, hazard_b}, {7'd0, mon_e.e_hz});
      end
    end
  end

  initial begin
    #1;
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    // Reset contents sweep.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(i), 3'(7 - i));
    // Write with same-cycle bypass, then array visibility.
    cyc(1'b0, 1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 3'd5, 3'd4);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd4);
    // Issue, observe busy, retire with bypass.
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 3'd4);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd4);
    cyc(1'b0, 1'b1, 3'd3, 8'h3C, 1'b0, 3'd0, 3'd3, 3'd4);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd4);
    // Same-register issue and retire: set wins.
    cyc(1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 3'd2, 3'd3);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd3);
    // Issue reg 6 with write to non-busy reg 7.
    cyc(1'b0, 1'b1, 3'd7, 8'h5E, 1'b1, 3'd6, 3'd6, 3'd7);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd7);
    // Reset mid-sequence discards pending issues and the write.
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd2);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd1, 3'd2);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd1, 3'd2);
    cyc(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0, 3'd0, 3'd1, 3'd4);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd4);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd6);
    // Register 0 write and issue (hardwired in instance B).
    cyc(1'b0, 1'b1, 3'd0, 8'h77, 1'b1, 3'd0, 3'd0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    cyc(1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 3'd0, 3'd1, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd0);
    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
